// File: rtl/inst_encode_if.sv
// Field/word handshake bundle for inst_encode.
// master drives fields and out_ready; slave is the encoder.
interface inst_encode_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2,
        output func3, func7, imm, out_ready,
        input  in_ready, out_valid, inst, addr, err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2,
        input  func3, func7, imm, out_ready,
        output in_ready, out_valid, inst, addr, err
    );
endinterface

// File: rtl/inst_encode.sv
// RV32I field-to-word encoder with a one-deep valid/ready output stage.
// Define INST_ENCODE_RANGE_CHECK_EN to flag immediates that do not fit.
module inst_encode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_encode_if.slave bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] r_inst;
    logic [31:0] r_addr;
    logic [31:0] r_ptr;
    logic        r_err;
    logic        r_valid;

    logic [31:0] w_imm;
    logic [31:0] w_inst;
    logic        w_fmt_err;
    logic        w_rng_err;
    logic        w_accept;

    assign w_imm    = bus.imm;
    assign w_accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !r_valid || bus.out_ready;
    assign bus.out_valid = r_valid;
    assign bus.inst      = r_inst;
    assign bus.addr      = r_addr;
    assign bus.err       = r_err;

    // Pack fields into the instruction word for the selected format
    always_comb begin
        w_inst    = NOP;
        w_fmt_err = 1'b0;
        case (bus.fmt)
            3'd0: w_inst = {bus.func7, bus.rs2, bus.rs1,
                            bus.func3, bus.rd, bus.opcode};
            3'd1: w_inst = {w_imm[11:0], bus.rs1,
                            bus.func3, bus.rd, bus.opcode};
            3'd2: w_inst = {w_imm[11:5], bus.rs2, bus.rs1,
                            bus.func3, w_imm[4:0], bus.opcode};
            3'd3: w_inst = {w_imm[12], w_imm[10:5], bus.rs2,
                            bus.rs1, bus.func3, w_imm[4:1],
                            w_imm[11], bus.opcode};
            3'd4: w_inst = {w_imm[31:12], bus.rd, bus.opcode};
            3'd5: w_inst = {w_imm[20], w_imm[10:1], w_imm[11],
                            w_imm[19:12], bus.rd, bus.opcode};
            default: begin
                w_inst    = NOP;
                w_fmt_err = 1'b1;
            end
        endcase
    end

`ifdef INST_ENCODE_RANGE_CHECK_EN
    // Flag immediates whose value would change after truncation
    always_comb begin
        w_rng_err = 1'b0;
        case (bus.fmt)
            3'd1, 3'd2:
                w_rng_err = (w_imm[31:11] != {21{w_imm[11]}});
            3'd3:
                w_rng_err = (w_imm[31:12] != {20{w_imm[12]}})
                            || w_imm[0];
            3'd4:
                w_rng_err = (w_imm[11:0] != 12'd0);
            3'd5:
                w_rng_err = (w_imm[31:20] != {12{w_imm[20]}})
                            || w_imm[0];
            default:
                w_rng_err = 1'b0;
        endcase
    end
`else
    assign w_rng_err = 1'b0;
`endif

    // Output register, valid flag and address pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= NOP;
            r_addr  <= BASE_ADDR;
            r_err   <= 1'b0;
            r_ptr   <= BASE_ADDR;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_inst  <= w_inst;
            r_addr  <= r_ptr;
            r_err   <= w_fmt_err || w_rng_err;
            r_ptr   <= r_ptr + 32'd4;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_inst_encode.sv
// Self-checking bench for inst_encode: directed table, corner
// sequences and randomized traffic against a scoreboard model.
module tb_inst_encode;
`ifdef INST_ENCODE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    inst_encode_if bus0 ();
    inst_encode_if bus1 ();

    inst_encode #(.BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    inst_encode #(.BASE_ADDR(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err_nr;
        logic        err_rc;
    } vec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    vec_t vt[11];
    exp_t q[$];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Reference encoder built from shifts/masks and signed ranges
    function automatic logic [32:0] ref_enc(
        logic [2:0] f, logic [6:0] op, logic [4:0] rd,
        logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
        logic [6:0] f7, logic [31:0] imm);
        logic [31:0] o, d, a, b, c3, c7, w;
        int  s;
        bit  bad, ill;
        o = 32'(op); d = 32'(rd); a = 32'(rs1); b = 32'(rs2);
        c3 = 32'(f3); c7 = 32'(f7);
        s = imm;
        bad = 1'b0;
        ill = 1'b0;
        case (f)
            3'd0: w = (c7 << 25) | (b << 20) | (a << 15)
                      | (c3 << 12) | (d << 7) | o;
            3'd1: begin
                w = ((imm & 32'hFFF) << 20) | (a << 15)
                    | (c3 << 12) | (d << 7) | o;
                bad = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (b << 20)
                    | (a << 15) | (c3 << 12)
                    | ((imm & 32'h1F) << 7) | o;
                bad = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = (((imm >> 12) & 32'h1) << 31)
                    | (((imm >> 5) & 32'h3F) << 25)
                    | (b << 20) | (a << 15) | (c3 << 12)
                    | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 32'h1) << 7) | o;
                bad = (s < -4096) || (s > 4095)
                      || ((imm & 32'h1) != 0);
            end
            3'd4: begin
                w = (imm & 32'hFFFF_F000) | (d << 7) | o;
                bad = (imm & 32'hFFF) != 0;
            end
            3'd5: begin
                w = (((imm >> 20) & 32'h1) << 31)
                    | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20)
                    | (((imm >> 12) & 32'hFF) << 12)
                    | (d << 7) | o;
                bad = (s < -1048576) || (s > 1048575)
                      || ((imm & 32'h1) != 0);
            end
            default: begin
                w = 32'h0000_0013;
                ill = 1'b1;
            end
        endcase
        return {ill || (RC && bad), w};
    endfunction

    task automatic drive0(vec_t v);
        bus0.fmt = v.fmt; bus0.opcode = v.op; bus0.rd = v.rd;
        bus0.rs1 = v.rs1; bus0.rs2 = v.rs2; bus0.func3 = v.f3;
        bus0.func7 = v.f7; bus0.imm = v.imm;
    endtask

    task automatic drive1(vec_t v);
        bus1.fmt = v.fmt; bus1.opcode = v.op; bus1.rd = v.rd;
        bus1.rs1 = v.rs1; bus1.rs2 = v.rs2; bus1.func3 = v.f3;
        bus1.func7 = v.f7; bus1.imm = v.imm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [32:0] e;
        logic [31:0] ptr;
        bit hs, acc;
        n_cmp = 0;
        n_bad = 0;
        vt[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'd5, 32'h0050_0093, 1'b0, 1'b0};
        vt[1]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 1'b0};
        vt[2]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'd8, 32'h0080_00EF, 1'b0, 1'b0};
        vt[3]  = '{3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,
                   32'd0, 32'h0000_0013, 1'b1, 1'b1};
        vt[4]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'd2048, 32'h8000_0093, 1'b0, 1'b1};
        vt[5]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20,
                   32'hDEAD_BEEF, 32'h4020_81B3, 1'b0, 1'b0};
        vt[6]  = '{3'd2, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F,
                   32'd8, 32'h0020_A423, 1'b0, 1'b0};
        vt[7]  = '{3'd4, 7'h37, 5'd5, 5'd9, 5'd9, 3'd7, 7'h7F,
                   32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0};
        vt[8]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'h1234_5678, 32'h1234_52B7, 1'b0, 1'b1};
        vt[9]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'd5, 32'h0000_0263, 1'b0, 1'b1};
        vt[10] = '{3'd7, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
                   32'h1234_5678, 32'h0000_0013, 1'b1, 1'b1};

        bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        drive0(vt[0]);
        drive1(vt[0]);
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_ovld", 32'(bus0.out_valid), 32'd0);
        chk("rst_inst", bus0.inst, 32'h0000_0013);
        chk("rst_addr", bus0.addr, 32'd0);
        chk("rst_err", 32'(bus0.err), 32'd0);
        chk("rst_irdy", 32'(bus0.in_ready), 32'd1);
        chk("rst_addr1", bus1.addr, 32'hFFFF_FFFC);

        // Directed table, one accept per cycle
        foreach (vt[i]) begin
            drive0(vt[i]);
            bus0.in_valid = 1'b1;
            #1;
            chk("tbl_irdy", 32'(bus0.in_ready), 32'd1);
            @(negedge clk);
            #1;
            chk($sformatf("tbl%0d_ovld", i), 32'(bus0.out_valid), 32'd1);
            chk($sformatf("tbl%0d_inst", i), bus0.inst, vt[i].inst);
            chk($sformatf("tbl%0d_err", i), 32'(bus0.err),
                32'(RC ? vt[i].err_rc : vt[i].err_nr));
            chk($sformatf("tbl%0d_addr", i), bus0.addr, 32'(i * 4));
        end
        bus0.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("tbl_drain", 32'(bus0.out_valid), 32'd0);

        // Stall with two back-to-back inputs
        do_reset();
        drive0(vt[0]);
        bus0.in_valid = 1'b1;
        bus0.out_ready = 1'b0;
        #1;
        chk("stl_irdy0", 32'(bus0.in_ready), 32'd1);
        @(negedge clk);
        drive0(vt[2]);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stl_irdy", 32'(bus0.in_ready), 32'd0);
            chk("stl_ovld", 32'(bus0.out_valid), 32'd1);
            chk("stl_inst", bus0.inst, vt[0].inst);
            chk("stl_addr", bus0.addr, 32'd0);
            @(negedge clk);
        end
        bus0.out_ready = 1'b1;
        #1;
        chk("stl_irdy1", 32'(bus0.in_ready), 32'd1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1;
        chk("stl_ovld2", 32'(bus0.out_valid), 32'd1);
        chk("stl_inst2", bus0.inst, vt[2].inst);
        chk("stl_addr2", bus0.addr, 32'd4);
        @(negedge clk);
        #1;
        chk("stl_drain", 32'(bus0.out_valid), 32'd0);

        // Reset while holding a stalled output
        drive0(vt[5]);
        bus0.in_valid = 1'b1;
        bus0.out_ready = 1'b0;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        #1;
        chk("mrs_ovld0", 32'(bus0.out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrs_ovld", 32'(bus0.out_valid), 32'd0);
        chk("mrs_addr", bus0.addr, 32'd0);
        chk("mrs_inst", bus0.inst, 32'h0000_0013);
        chk("mrs_irdy", 32'(bus0.in_ready), 32'd1);
        bus0.out_ready = 1'b1;

        // Pointer wrap on the high-base instance
        drive1(vt[0]);
        bus1.in_valid = 1'b1;
        @(negedge clk);
        drive1(vt[7]);
        #1;
        chk("wrp_addr0", bus1.addr, 32'hFFFF_FFFC);
        chk("wrp_inst0", bus1.inst, vt[0].inst);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        #1;
        chk("wrp_addr1", bus1.addr, 32'd0);
        chk("wrp_inst1", bus1.inst, vt[7].inst);

        // Randomized traffic against the scoreboard
        do_reset();
        ptr = 32'd0;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            bus0.in_valid  = ($urandom_range(0, 3) != 0);
            bus0.out_ready = ($urandom_range(0, 2) != 0);
            bus0.fmt    = 3'($urandom_range(0, 7));
            bus0.opcode = 7'($urandom);
            bus0.rd     = 5'($urandom);
            bus0.rs1    = 5'($urandom);
            bus0.rs2    = 5'($urandom);
            bus0.func3  = 3'($urandom);
            bus0.func7  = 7'($urandom);
            case ($urandom_range(0, 3))
                0: bus0.imm = $urandom;
                1: bus0.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: bus0.imm = 32'($urandom_range(0, 4095)) << 12;
                default: bus0.imm = 32'($urandom_range(0, 2097151))
                                    - 32'd1048576;
            endcase
            #1;
            chk("rnd_ovld", 32'(bus0.out_valid), 32'(q.size() != 0));
            chk("rnd_irdy", 32'(bus0.in_ready),
                32'((q.size() == 0) || bus0.out_ready));
            if (q.size() != 0) begin
                chk("rnd_inst", bus0.inst, q[0].inst);
                chk("rnd_addr", bus0.addr, q[0].addr);
                chk("rnd_err", 32'(bus0.err), 32'(q[0].err));
            end
            hs  = (q.size() != 0) && bus0.out_ready;
            acc = bus0.in_valid && ((q.size() == 0) || bus0.out_ready);
            if (hs) void'(q.pop_front());
            if (acc) begin
                e = ref_enc(bus0.fmt, bus0.opcode, bus0.rd, bus0.rs1,
                            bus0.rs2, bus0.func3, bus0.func7, bus0.imm);
                q.push_back('{e[31:0], ptr, e[32]});
                ptr = ptr + 32'd4;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_encode.md
INST_ENCODE -- requirements
Module: inst_encode

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the address tagged to the first instruction after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning the field set is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the encoder accepts fields this cycle.
REQ-006 SHALL have port fmt, input, 3, the format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-007 SHALL have port opcode, input, 7, the opcode field.
REQ-008 SHALL have ports rd, rs1 and rs2, input, 5 each, the register fields.
REQ-009 SHALL have ports func3 (input, 3) and func7 (input, 7), the function fields.
REQ-010 SHALL have port imm, input, 32, the full signed or unsigned immediate value (unscrambled).
REQ-011 SHALL have port out_valid, output, 1, meaning inst, addr and err are valid.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer takes the output this cycle.
REQ-013 SHALL have port inst, output, 32, the encoded RV32I instruction word.
REQ-014 SHALL have port addr, output, 32, the program address tagged to inst.
REQ-015 SHALL have port err, output, 1, the encoding error flag for inst.

Function
REQ-016 SHALL set in_ready = !out_valid || out_ready (combinational); accept when in_valid && in_ready.
REQ-017 SHALL register inst, addr and err on accept; out_valid=1 on the next cycle (latency 1).
REQ-018 SHALL clear out_valid after an output handshake with no accept in the same cycle; on a simultaneous handshake and accept, out_valid stays 1 and the output register reloads.
REQ-019 SHALL hold inst, addr and err stable while out_valid && !out_ready.
REQ-020 SHALL keep a 32-bit write pointer: addr = pointer at accept; pointer += 4 per accept; 32'hFFFF_FFFC wraps to 0.
REQ-021 SHALL place opcode at [6:0] for every format.
REQ-022 SHALL encode R as {func7, rs2, rs1, func3, rd, opcode}.
REQ-023 SHALL encode I as {imm[11:0], rs1, func3, rd, opcode}.
REQ-024 SHALL encode S as {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
REQ-025 SHALL encode B as {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
REQ-026 SHALL encode U as {imm[31:12], rd, opcode}.
REQ-027 SHALL encode J as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-028 SHALL output inst=32'h0000_0013 (NOP) with err=1 for an illegal fmt; the pointer still advances.
REQ-029 SHALL ignore fields unused by the selected format.

Reset
REQ-030 SHALL on rst set out_valid=0, inst=32'h0000_0013, addr=BASE_ADDR, err=0 and pointer=BASE_ADDR.
REQ-031 SHALL discard any held output when rst is asserted mid-transfer; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-032 SHALL with INST_ENCODE_RANGE_CHECK_EN defined set err=1 when imm does not fit the format:
- I/S: not a 12-bit sign extension.
- B: not 13-bit signed, or imm[0]=1.
- J: not 21-bit signed, or imm[0]=1.
- U: imm[11:0] != 0.
The truncated encoding is still output.
REQ-033 SHALL without INST_ENCODE_RANGE_CHECK_EN raise err only for an illegal fmt and silently truncate imm.

Verification
REQ-034 SHALL cover: fmt=I, opcode=7'h13, rd=1, rs1=0, func3=0, imm=5 -> inst=32'h0050_0093, addr=BASE_ADDR, err=0, one cycle later.
REQ-035 SHALL cover: fmt=B, opcode=7'h63, rs1=rs2=0, func3=0, imm=32'hFFFF_FFFC -> inst=32'hFE00_0EE3.
REQ-036 SHALL cover: fmt=J, opcode=7'h6F, rd=1, imm=8 -> inst=32'h0080_00EF; then fmt=6 -> inst=32'h0000_0013, err=1.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with 2 back-to-back inputs -> in_ready=0 while stalled, no loss or duplication, addr 0 then 4.
REQ-038 SHALL cover: fmt=I, imm=2048 -> err=1 with the macro, err=0 without it; inst[31:20]=12'h800 in both builds.
REQ-039 SHALL cover: rst asserted while out_valid=1 and stalled -> next cycle out_valid=0, addr=BASE_ADDR; BASE_ADDR=32'hFFFF_FFFC with two inputs -> addr FFFF_FFFC then 0.
